// File: rtl/lsu_wb_pipe_if.sv
// Handshake bundle between the issue side, the LSU response port and writeback
// for lsu_wb_pipe.
interface lsu_wb_pipe_if #(
   parameter int DW = 128,
   parameter int RW = 64
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_payload;
   logic [RW-1:0] in_result;
   logic          in_mem;
   logic          rsp_valid;
   logic [RW-1:0] rsp_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_payload;
   logic [RW-1:0] out_result;
   logic          err_unexpected_rsp;

   modport slave (
      input  in_valid, in_payload, in_result, in_mem, rsp_valid, rsp_data, flush, out_ready,
      output in_ready, out_valid, out_payload, out_result, err_unexpected_rsp
   );

   modport master (
      output in_valid, in_payload, in_result, in_mem, rsp_valid, rsp_data, flush, out_ready,
      input  in_ready, out_valid, out_payload, out_result, err_unexpected_rsp
   );
endinterface

// File: rtl/lsu_wb_pipe.sv
// In-order writeback buffer: entries wait for in-order LSU responses, then
// drain to WB from the head. Responses owed to flushed entries are dropped.
module lsu_wb_pipe #(
   parameter int DW    = 128,
   parameter int RW    = 64,
   parameter int DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   lsu_wb_pipe_if.slave bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} slot_e;

   slot_e         r_state   [DEPTH];
   slot_e         w_state_n [DEPTH];
   logic [DW-1:0] r_payload [DEPTH];
   logic [DW-1:0] w_payload_n [DEPTH];
   logic [RW-1:0] r_result  [DEPTH];
   logic [RW-1:0] w_result_n [DEPTH];

   logic [PW-1:0] r_rptr, r_wptr, w_rptr_n, w_wptr_n, w_wait_idx, w_idx;
   logic [CW-1:0] r_cnt, w_cnt_n, r_drop, w_drop_n, w_n_wait;
   logic          r_in_ready, w_in_ready_n, r_err, w_err_n;
   logic          w_has_wait, w_push, w_pop, w_rsp_used;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign bus.in_ready           = r_in_ready;
   assign bus.out_valid          = (r_state[r_rptr] == S_DONE);
   assign bus.out_payload        = r_payload[r_rptr];
   assign bus.out_result         = r_result[r_rptr];
   assign bus.err_unexpected_rsp = r_err;

   assign w_push = bus.in_valid && r_in_ready && !bus.flush;
   assign w_pop  = bus.out_valid && bus.out_ready;

   // Walk from the head backwards so the oldest WAIT slot is the last one written.
   always_comb begin
      w_has_wait = 1'b0;
      w_wait_idx = '0;
      w_n_wait   = '0;
      w_idx      = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         w_idx = r_rptr + PW'(k);
         if (r_state[w_idx] == S_WAIT) begin
            w_has_wait = 1'b1;
            w_wait_idx = w_idx;
            w_n_wait   = w_n_wait + CW'(1);
         end
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_payload_n = r_payload;
      w_result_n  = r_result;
      w_rptr_n    = r_rptr;
      w_wptr_n    = r_wptr;
      w_drop_n    = r_drop;
      w_err_n     = r_err;
      w_rsp_used  = 1'b0;

      // The response sees pre-push state, so it can never land on a fresh entry.
      if (bus.rsp_valid) begin
         if (r_drop != '0) begin
            w_drop_n   = r_drop - CW'(1);
            w_rsp_used = 1'b1;
         end else if (w_has_wait) begin
            w_state_n[w_wait_idx]  = S_DONE;
            w_result_n[w_wait_idx] = bus.rsp_data;
            w_rsp_used             = 1'b1;
         end else begin
            w_err_n = 1'b1;
         end
      end

      if (w_pop) begin
         w_state_n[r_rptr] = S_EMPTY;
         w_rptr_n          = f_inc(r_rptr);
      end

      if (w_push) begin
         w_state_n[r_wptr]   = bus.in_mem ? S_WAIT : S_DONE;
         w_payload_n[r_wptr] = bus.in_payload;
         w_result_n[r_wptr]  = bus.in_mem ? '0 : bus.in_result;
         w_wptr_n            = f_inc(r_wptr);
      end

      w_cnt_n = r_cnt + CW'(w_push) - CW'(w_pop);

      if (bus.flush) begin
         for (int i = 0; i < DEPTH; i++) w_state_n[i] = S_EMPTY;
         w_rptr_n = '0;
         w_wptr_n = '0;
         w_cnt_n  = '0;
         w_drop_n = r_drop + w_n_wait - CW'(w_rsp_used);
      end

      w_in_ready_n = (w_cnt_n < CW'(DEPTH)) && (w_drop_n == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_state[i]   <= S_EMPTY;
            r_payload[i] <= '0;
            r_result[i]  <= '0;
         end
         r_rptr     <= '0;
         r_wptr     <= '0;
         r_cnt      <= '0;
         r_drop     <= '0;
         r_in_ready <= 1'b1;
         r_err      <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            r_state[i]   <= w_state_n[i];
            r_payload[i] <= w_payload_n[i];
            r_result[i]  <= w_result_n[i];
         end
         r_rptr     <= w_rptr_n;
         r_wptr     <= w_wptr_n;
         r_cnt      <= w_cnt_n;
         r_drop     <= w_drop_n;
         r_in_ready <= w_in_ready_n;
         r_err      <= w_err_n;
      end
   end
endmodule

// File: tb/tb_lsu_wb_pipe.sv
// Scoreboard bench for lsu_wb_pipe: directed scenarios followed by random
// traffic, all checked against a queue-based model of the buffer.
module tb_lsu_wb_pipe;
   localparam int DW = 32;
   localparam int RW = 64;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_wb_pipe_if #(.DW(DW), .RW(RW)) bus ();
   lsu_wb_pipe #(.DW(DW), .RW(RW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [DW-1:0] pay;
      bit            done;
      logic [RW-1:0] res;
   } ent_t;

   ent_t mq[$];
   int   owed = 0;
   bit   merr = 1'b0;
   bit   chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_pop = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic int outstanding();
      int n;
      n = owed;
      foreach (mq[i]) if (!mq[i].done) n++;
      return n;
   endfunction

   // Monitor: compare against the model, then advance the model over the coming edge.
   always @(negedge clk) begin
      bit   exp_v, exp_rdy, found;
      ent_t e;
      exp_v   = (mq.size() > 0) && mq[0].done;
      exp_rdy = (mq.size() < DEPTH) && (owed == 0);
      if (chk_en) begin
         chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
         chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         chk("err_unexpected_rsp", 64'(bus.err_unexpected_rsp), 64'(merr));
         if (exp_v && bus.out_valid) begin
            chk("out_payload", 64'(bus.out_payload), 64'(mq[0].pay));
            chk("out_result", 64'(bus.out_result), 64'(mq[0].res));
         end
      end
      if (rst) begin
         mq.delete();
         owed = 0;
         merr = 1'b0;
      end else begin
         if (bus.rsp_valid) begin
            if (owed > 0) owed--;
            else begin
               found = 1'b0;
               foreach (mq[i]) if (!found && !mq[i].done) begin
                  mq[i].done = 1'b1;
                  mq[i].res  = bus.rsp_data;
                  found      = 1'b1;
               end
               if (!found) merr = 1'b1;
            end
         end
         if (exp_v && bus.out_ready) begin
            void'(mq.pop_front());
            n_pop++;
         end
         if (bus.flush) begin
            foreach (mq[i]) if (!mq[i].done) owed++;
            mq.delete();
         end else if (bus.in_valid && exp_rdy) begin
            e.pay  = bus.in_payload;
            e.done = !bus.in_mem;
            e.res  = bus.in_mem ? '0 : bus.in_result;
            mq.push_back(e);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drv_idle();
      bus.in_valid  = 1'b0;
      bus.in_mem    = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.flush     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv_idle();
      bus.out_ready = 1'b0;
      step(2);
      chk("rst_out_payload", 64'(bus.out_payload), 64'h0);
      chk("rst_out_result", bus.out_result, 64'h0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk_en = 1'b1;
      rst = 1'b0;
      step(1);
   endtask

   task automatic push(input bit mem, input logic [RW-1:0] res);
      bus.in_valid   = 1'b1;
      bus.in_mem     = mem;
      bus.in_result  = res;
      bus.in_payload = DW'($urandom);
      step(1);
      bus.in_valid = 1'b0;
      bus.in_mem   = 1'b0;
   endtask

   task automatic rsp(input logic [RW-1:0] d);
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = d;
      step(1);
      bus.rsp_valid = 1'b0;
   endtask

   initial begin
      int p0;
      bus.in_payload = '0;
      bus.in_result  = '0;
      bus.rsp_data   = '0;
      do_reset();

      // Back-to-back non-mem pushes drain with one-cycle latency.
      bus.out_ready = 1'b1;
      push(1'b0, 64'h11);
      push(1'b0, 64'h22);
      chk("d34_in_ready", 64'(bus.in_ready), 64'h1);
      step(3);

      // Mem head blocks a completed younger entry until its response.
      push(1'b1, 64'hBAD);
      push(1'b0, 64'h5);
      chk("d35_in_ready_full", 64'(bus.in_ready), 64'h0);
      step(2);
      rsp(64'hDEAD);
      step(3);

      // Flush two waiting entries: both responses are owed and dropped.
      bus.out_ready = 1'b0;
      push(1'b1, 64'h0);
      push(1'b1, 64'h0);
      bus.flush = 1'b1;
      step(1);
      bus.flush = 1'b0;
      chk("d36_in_ready_owed2", 64'(bus.in_ready), 64'h0);
      step(2);
      rsp(64'h1234);
      chk("d36_in_ready_owed1", 64'(bus.in_ready), 64'h0);
      rsp(64'h5678);
      chk("d36_in_ready_clear", 64'(bus.in_ready), 64'h1);
      chk("d36_no_err", 64'(bus.err_unexpected_rsp), 64'h0);

      // Response in the flush cycle is absorbed by the flushed entry.
      push(1'b1, 64'h0);
      bus.flush     = 1'b1;
      bus.rsp_valid = 1'b1;
      bus.rsp_data  = 64'hCAFE;
      step(1);
      drv_idle();
      chk("d37_in_ready", 64'(bus.in_ready), 64'h1);
      step(1);

      // Unexpected response: sticky across flush, cleared by reset.
      rsp(64'h99);
      chk("d38_err_set", 64'(bus.err_unexpected_rsp), 64'h1);
      bus.flush = 1'b1;
      step(1);
      bus.flush = 1'b0;
      chk("d38_err_after_flush", 64'(bus.err_unexpected_rsp), 64'h1);
      do_reset();
      chk("d38_err_after_rst", 64'(bus.err_unexpected_rsp), 64'h0);

      // Full buffer then continuous streaming: one pop per cycle across wraps.
      bus.out_ready = 1'b0;
      push(1'b0, 64'hA0);
      push(1'b0, 64'hA1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      p0 = n_pop;
      for (int i = 0; i < 8; i++) begin
         bus.in_result  = 64'hB0 + 64'(i);
         bus.in_payload = DW'($urandom);
         step(1);
      end
      bus.in_valid = 1'b0;
      chk("d39_pops_in_8", 64'(n_pop - p0), 64'd8);
      step(4);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         bus.in_valid   = ($urandom % 2) == 0;
         bus.in_mem     = ($urandom % 2) == 0;
         bus.in_payload = DW'($urandom);
         bus.in_result  = {32'($urandom), 32'($urandom)};
         bus.out_ready  = ($urandom % 4) != 0;
         bus.rsp_valid  = ((outstanding() > 0) && ($urandom % 3 == 0)) || ($urandom % 600 == 0);
         bus.rsp_data   = {32'($urandom), 32'($urandom)};
         bus.flush      = ($urandom % 40) == 0;
         rst            = ($urandom % 500) == 0;
         step(1);
      end
      rst = 1'b0;
      drv_idle();
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lsu_wb_pipe.md
LSU_WB_PIPE -- requirements
Module: lsu_wb_pipe

Interface
REQ-001 SHALL have parameter DW, default 128, meaning the width of the pass-through control/payload bundle (pc, inst, rd, write-enables, etc.).
REQ-002 SHALL have parameter RW, default 64, meaning the writeback result width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning the number of buffered entries; legal values are powers of two from 1 to 8.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the upstream handshake; a push occurs when both are high.
REQ-007 SHALL have ports in_payload (input, DW) and in_result (input, RW): the bundle and the EXU/CSR result.
REQ-008 SHALL have port in_mem, input, 1 bit: the entry awaits one LSU response (load data or store ack).
REQ-009 SHALL have ports rsp_valid (input, 1) and rsp_data (input, RW): LSU responses, returned in issue order, always accepted.
REQ-010 SHALL have port flush, input, 1 bit: kill all buffered entries.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the downstream (WB) handshake; a pop occurs when both are high.
REQ-012 SHALL have ports out_payload (output, DW) and out_result (output, RW): the head entry.
REQ-013 SHALL have port err_unexpected_rsp, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 SHALL hold entries in a FIFO of DEPTH slots; each slot's state is one of EMPTY, WAIT or DONE.
REQ-015 A pushed entry SHALL become WAIT if in_mem=1, else DONE with result=in_result.
REQ-016 in_ready SHALL be a registered function of internal state only, never of out_ready or rsp_valid in the same cycle: in_ready = (occupancy<DEPTH) and (drop_cnt==0).
REQ-017 out_valid SHALL equal (head state==DONE), and out_payload/out_result SHALL be driven from the head slot; zero added latency.
REQ-018 A non-mem entry SHALL be poppable the cycle after its push (1-cycle latency).
REQ-019 A mem entry SHALL be poppable the cycle after the rsp_valid that completes it.
REQ-020 When drop_cnt==0, rsp_valid SHALL store rsp_data into the oldest WAIT slot and set that slot to DONE.
REQ-021 A response SHALL never complete an entry pushed in the same cycle.
REQ-022 A same-cycle push and pop SHALL both take effect; occupancy is unchanged and the read and write pointers each advance, wrapping modulo DEPTH.
REQ-023 A same-cycle pop and rsp_valid SHALL both take effect; the response targets the oldest WAIT slot, which is never the popped DONE head.
REQ-024 On flush, all slots SHALL become EMPTY and both pointers SHALL reset; a push in the same cycle is discarded; out_valid is 0 the next cycle.
REQ-025 drop_cnt (width clog2(DEPTH+1)) SHALL count responses still owed to flushed entries.
REQ-026 On flush, drop_cnt_next SHALL equal drop_cnt + (number of WAIT slots) - rsp_valid, where a response in the flush cycle is consumed by the pre-flush state.
REQ-027 When drop_cnt>0, rsp_valid SHALL decrement drop_cnt and discard rsp_data.
REQ-028 rsp_valid arriving with drop_cnt==0 and no WAIT slot SHALL set err_unexpected_rsp; the response is ignored and err_unexpected_rsp stays set until rst.
REQ-029 A pop while out_valid=0 SHALL have no effect.
REQ-030 flush SHALL NOT clear err_unexpected_rsp.

Reset
REQ-031 While rst=1, all slots SHALL be EMPTY, pointers 0, drop_cnt 0, and out_payload/out_result 0.
REQ-032 The cycle after rst, outputs SHALL be in_ready=1, out_valid=0 and err_unexpected_rsp=0.
REQ-033 rst SHALL take priority over flush, push, pop and rsp_valid; a rst mid-operation discards everything, including owed responses.

Verification
REQ-034 DW=32, RW=64, DEPTH=2; push non-mem result 0x11, then 0x22, with out_ready=1 -> out_valid cycles 1 and 2 with results 0x11, 0x22; in_ready stays 1.
REQ-035 Push mem A, then non-mem B=0x5; rsp_data=0xDEAD three cycles later -> B is held behind A; pops A=0xDEAD, then B=0x5; in_ready=0 while two slots are occupied.
REQ-036 Two mem entries in WAIT, flush with no response -> drop_cnt=2 and in_ready=0; the next two responses are discarded; in_ready=1 after the second; no err.
REQ-037 One WAIT entry, flush and rsp_valid in the same cycle -> drop_cnt=0, the response is consumed, and in_ready=1 the next cycle.
REQ-038 FIFO empty, drop_cnt=0, rsp_valid=1 -> err_unexpected_rsp=1 and it stays 1 across a flush; cleared only by rst.
REQ-039 Full FIFO with out_ready=1 and a continuous push of non-mem entries over 8 cycles -> one pop per cycle, pointer wrap verified, order preserved.
